// File: rtl/xout_change_capture.sv
// xout_change_capture: samples XIN, queues each change in a FIFO and counts the pushes that overflow drops
module xout_change_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     EN,
  input  logic [WIDTH-1:0]         XIN,
  output logic [WIDTH-1:0]         XOUT,
  output logic                     XOUT_VALID,
  input  logic                     XOUT_READY,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic [CNTW-1:0]          DROPS
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);
  typedef enum logic [1:0] {IDLE, PRIME, TRACK} state_t;
  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] last;
  logic [AW-1:0]    rd, wr;
  logic             pop, push_req, push, full;
  // a full FIFO still takes a push when the head leaves at the same edge
  always_comb begin
    pop      = XOUT_VALID && XOUT_READY;
    full     = LEVEL == FULL_LVL;
    push_req = EN && (state == PRIME || (state == TRACK && XIN != last));
    push     = push_req && (!full || pop);
  end
  assign XOUT_VALID = LEVEL != '0;
  // capture FSM: EN low always returns to IDLE so re-enabling re-primes
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      last  <= '0;
    end else if (!EN) begin
      state <= IDLE;
    end else begin
      state <= state == IDLE ? PRIME : TRACK;
      if (state != IDLE) last <= XIN;
    end
  end
  // storage array needs no reset; occupancy alone decides what is valid
  always_ff @(posedge CLK) begin
    if (push) mem[wr] <= XIN;
  end
  // pointers, exact occupancy, registered head and saturating drop counter
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd    <= '0;
      wr    <= '0;
      LEVEL <= '0;
      XOUT  <= '0;
      DROPS <= '0;
    end else begin
      if (push) wr <= wr + AW'(1);
      if (pop) rd <= rd + AW'(1);
      LEVEL <= LEVEL + (AW+1)'(push) - (AW+1)'(pop);
      if (pop && LEVEL > ONE_LVL) XOUT <= mem[rd + AW'(1)];
      else if (push && (LEVEL == '0 || (pop && LEVEL == ONE_LVL))) XOUT <= XIN;
      if (push_req && full && !pop && DROPS != '1) DROPS <= DROPS + CNTW'(1);
    end
  end
endmodule
